// File: rtl/uart_tx_arb_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arb_if
// Bundles every non-clock signal of uart_tx_arb: the per-requester handshake
// (req/wdata/ack/done/err/err_clr), status (busy/owner), the watchdog limit
// (tmo) and the uart_tx side (tx_push/tx_clear/tx_wdata/tx_empty).
//   slave  : the arbiter side (drives ack/done/err/busy/owner/tx_*).
//   master : the environment side (requesters plus the uart_tx instance).
// Parameters:
//   N    : number of requesters (2..8)
//   TMSB : MSB of the watchdog limit tmo
// ---------------------------------------------------------------------------
interface uart_tx_arb_if #(
    parameter int N    = 4,
    parameter int TMSB = 15
) ();
    localparam int OW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [8*N-1:0] wdata;
    logic [N-1:0]   ack;
    logic [N-1:0]   done;
    logic [N-1:0]   err;
    logic [N-1:0]   err_clr;
    logic           busy;
    logic [OW-1:0]  owner;
    logic [TMSB:0]  tmo;
    logic           tx_push;
    logic           tx_clear;
    logic [7:0]     tx_wdata;
    logic           tx_empty;

    modport master (
        output req, wdata, err_clr, tmo, tx_empty,
        input  ack, done, err, busy, owner, tx_push, tx_clear, tx_wdata
    );

    modport slave (
        input  req, wdata, err_clr, tmo, tx_empty,
        output ack, done, err, busy, owner, tx_push, tx_clear, tx_wdata
    );
endinterface

// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
// Round-robin arbiter sharing one uart_tx byte transmitter between N
// requesters. A winner's byte is registered, pushed with a one-cycle strobe,
// and the transmitter's empty flag is then tracked until the frame ends. A
// programmable watchdog aborts a stuck frame, clears the transmitter and
// raises a sticky error flag for the owning requester.
// Ports:
//   clk  : single clock
//   rst  : asynchronous active-high reset
//   bus  : uart_tx_arb_if.slave
//          req/wdata in, ack/done pulses out, err sticky out, err_clr in,
//          busy/owner status out, tmo watchdog limit in (0 = off),
//          tx_push/tx_clear strobes out, tx_wdata out, tx_empty in.
// ---------------------------------------------------------------------------
module uart_tx_arb #(
    parameter int N    = 4,
    parameter int TMSB = 15
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_arb_if.slave   bus
);
    localparam int OW = (N > 1) ? $clog2(N) : 1;
    localparam logic [OW:0]   NW       = (OW+1)'(N);
    localparam logic [TMSB:0] WDOG_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_ABORT
    } state_t;

    state_t         r_state, w_state_next;
    logic [OW-1:0]  r_rr, w_rr_next;
    logic [OW-1:0]  r_owner, w_owner_next;
    logic [7:0]     r_tx_wdata, w_tx_wdata_next;
    logic [N-1:0]   r_err, w_err_next;
    logic [N-1:0]   r_done, w_done_next;
    logic [TMSB:0]  r_wdog, w_wdog_next;

    logic [TMSB:0]  w_wdog_inc;
    logic           w_timeout;
    logic [N-1:0]   w_owner_oh;
    logic [N-1:0]   w_req_rot;
    logic [OW-1:0]  w_rot_idx [N];
    logic           w_found;
    logic [OW-1:0]  w_pick;
    logic [OW-1:0]  w_owner_inc;

    // Rotate the request vector so that position 0 is the rr pointer; the
    // lowest set bit of the rotated vector is then the round-robin winner.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        logic [OW:0] w_sum;
        assign w_sum           = {1'b0, r_rr} + (OW+1)'(gi);
        assign w_rot_idx[gi]   = (w_sum >= NW) ? OW'(w_sum - NW) : OW'(w_sum);
        assign w_req_rot[gi]   = bus.req[w_rot_idx[gi]];
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_oh
        assign w_owner_oh[gi] = (r_owner == OW'(gi));
        assign bus.ack[gi]    = (r_state == S_LOAD) && w_owner_oh[gi];
    end

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        // Scan downward so the smallest rotated offset wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_found = 1'b1;
                w_pick  = w_rot_idx[k];
            end
        end
    end

    assign w_owner_inc = (r_owner == OW'(N - 1)) ? '0 : r_owner + OW'(1);

    // Saturating watchdog; w_wdog_inc is the number of wait cycles including
    // the current one, so the compare fires on the tmo-th wait cycle and
    // ABORT follows tmo+1 cycles after LOAD.
    assign w_wdog_inc = (r_wdog == WDOG_MAX) ? r_wdog : r_wdog + (TMSB+1)'(1);
    assign w_timeout  = (bus.tmo != '0) && (w_wdog_inc == bus.tmo);

    always_comb begin
        w_state_next    = r_state;
        w_rr_next       = r_rr;
        w_owner_next    = r_owner;
        w_tx_wdata_next = r_tx_wdata;
        w_done_next     = '0;
        w_wdog_next     = r_wdog;
        // Clear first, then OR in any set below so set wins.
        w_err_next      = r_err & ~bus.err_clr;

        case (r_state)
            S_IDLE: begin
                // The cycle carrying a completion done pulse is not a grant
                // cycle; this keeps done at d and the next push at d+2.
                if (w_found && bus.tx_empty && (r_done == '0)) begin
                    w_owner_next    = w_pick;
                    w_tx_wdata_next = bus.wdata[{w_pick, 3'b000} +: 8];
                    w_state_next    = S_LOAD;
                end
            end
            S_LOAD: begin
                w_wdog_next  = '0;
                w_state_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                w_wdog_next = w_wdog_inc;
                if (w_timeout) begin
                    w_done_next  = w_owner_oh;
                    w_state_next = S_ABORT;
                end else if (!bus.tx_empty) begin
                    w_state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                w_wdog_next = w_wdog_inc;
                if (w_timeout) begin
                    w_done_next  = w_owner_oh;
                    w_state_next = S_ABORT;
                end else if (bus.tx_empty) begin
                    w_done_next  = w_owner_oh;
                    w_rr_next    = w_owner_inc;
                    w_state_next = S_IDLE;
                end
            end
            S_ABORT: begin
                w_err_next   = w_err_next | w_owner_oh;
                w_rr_next    = w_owner_inc;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr       <= '0;
            r_owner    <= '0;
            r_tx_wdata <= '0;
            r_err      <= '0;
            r_done     <= '0;
            r_wdog     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_rr       <= w_rr_next;
            r_owner    <= w_owner_next;
            r_tx_wdata <= w_tx_wdata_next;
            r_err      <= w_err_next;
            r_done     <= w_done_next;
            r_wdog     <= w_wdog_next;
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.tx_push  = (r_state == S_LOAD);
    assign bus.tx_clear = (r_state == S_ABORT);
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.owner    = r_owner;
    assign bus.tx_wdata = r_tx_wdata;
endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;
    localparam int N    = 4;
    localparam int TMSB = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arb_if #(.N(N), .TMSB(TMSB)) bus_if ();
    uart_tx_arb #(.N(N), .TMSB(TMSB)) dut (.clk(clk), .rst(rst), .bus(bus_if));

    typedef struct {
        int idx;
        int data;
        bit abort;
        int tmo;
        int dur;
        int exp_push;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    bit   inflight   = 0;
    exp_t cur;
    exp_t mon_e;
    int   push_cyc   = 0;
    int   last_done  = 0;
    bit   prev_push  = 0;
    bit   prev_done  = 0;
    bit   prev_clear = 0;

    int   g_d1 = 2;
    int   g_d2 = 20;
    bit   g_stuck = 0;
    bit   tx_block = 0;
    logic m_empty = 1'b1;
    int   tx_cnt = 0;
    bit   tx_run = 0;

    logic [N-1:0] m_err = '0;
    int           m_rr  = 0;

    assign bus_if.tx_empty = m_empty & ~tx_block;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Behavioural uart_tx: after a push, empty drops d1 cycles later and
    // returns d2 cycles after that; stuck mode never leaves empty.
    initial begin
        forever begin
            @(negedge clk);
            if (rst || bus_if.tx_clear) begin
                m_empty = 1'b1;
                tx_run  = 0;
            end else if (bus_if.tx_push) begin
                tx_run  = !g_stuck;
                tx_cnt  = 0;
                m_empty = 1'b1;
            end else if (tx_run) begin
                tx_cnt++;
                m_empty = !(tx_cnt >= g_d1 && tx_cnt < g_d1 + g_d2);
                if (tx_cnt >= g_d1 + g_d2) tx_run = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each push and checks completion.
    always @(negedge clk) begin
        if (rst) begin
            inflight   = 0;
            prev_push  = 0;
            prev_done  = 0;
            prev_clear = 0;
        end else begin
            if (bus_if.tx_push) begin
                check("push_pulse_width", prev_push, 0);
                if (sb.size() == 0) begin
                    fail("unexpected_push");
                end else begin
                    mon_e = sb.pop_front();
                    check("push_cycle", cyc,
                          (mon_e.exp_push >= 0) ? mon_e.exp_push : last_done + 2);
                    check("owner", bus_if.owner, mon_e.idx);
                    check("tx_wdata", bus_if.tx_wdata, mon_e.data);
                    check("ack_onehot", bus_if.ack, 64'd1 << mon_e.idx);
                    check("busy_in_load", bus_if.busy, 1);
                    cur      = mon_e;
                    inflight = 1;
                    push_cyc = cyc;
                end
            end
            if (bus_if.tx_clear) begin
                check("clear_pulse_width", prev_clear, 0);
                if (!inflight || !cur.abort) fail("unexpected_clear");
                else check("clear_delay", cyc - push_cyc, cur.tmo + 1);
            end
            if (bus_if.done != '0) begin
                check("done_pulse_width", prev_done, 0);
                if (!inflight) begin
                    fail("unexpected_done");
                end else begin
                    check("done_onehot", bus_if.done, 64'd1 << cur.idx);
                    check("done_delay", cyc - push_cyc, cur.dur);
                    check("abort_path", bus_if.tx_clear, cur.abort);
                    $display("txn owner=%0d data=%02h abort=%0d push@%0d done@%0d",
                             cur.idx, cur.data, cur.abort, push_cyc, cyc);
                    inflight  = 0;
                    last_done = cyc;
                end
            end
            prev_push  = bus_if.tx_push;
            prev_done  = (bus_if.done != '0);
            prev_clear = bus_if.tx_clear;
        end
    end

    task automatic check_reset_values();
        check("rst_busy", bus_if.busy, 0);
        check("rst_tx_push", bus_if.tx_push, 0);
        check("rst_tx_clear", bus_if.tx_clear, 0);
        check("rst_ack", bus_if.ack, 0);
        check("rst_done", bus_if.done, 0);
        check("rst_err", bus_if.err, 0);
        check("rst_owner", bus_if.owner, 0);
        check("rst_tx_wdata", bus_if.tx_wdata, 0);
    endtask

    // Reference: all requests of a round rise together and are served in
    // cyclic order from the pointer; a frame aborts when the watchdog limit
    // is reached no later than the cycle the transmitter returns to empty.
    task automatic predict(input logic [N-1:0] mask, input logic [8*N-1:0] data,
                           input int d1, input int d2, input bit stuck,
                           input int tmo_v, input int blk);
        int   idx;
        int   last;
        bit   first;
        exp_t e;
        first = 1;
        last  = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (mask[idx]) begin
                e.idx      = idx;
                e.data     = int'(data[8*idx +: 8]);
                e.abort    = (tmo_v != 0) && (stuck || tmo_v <= d1 + d2);
                e.tmo      = tmo_v;
                e.dur      = e.abort ? tmo_v + 1 : d1 + d2 + 1;
                e.exp_push = first ? cyc + blk + 1 : -1;
                first      = 0;
                sb.push_back(e);
                if (e.abort) m_err[idx] = 1'b1;
                last = idx;
            end
        end
        if (last >= 0) m_rr = (last + 1) % N;
    endtask

    task automatic run_round(input logic [N-1:0] mask, input logic [8*N-1:0] data,
                             input int d1, input int d2, input bit stuck,
                             input int tmo_v, input int blk, input logic [N-1:0] clr);
        int n;
        g_d1        = d1;
        g_d2        = d2;
        g_stuck     = stuck;
        bus_if.tmo  = (TMSB+1)'(tmo_v);
        @(negedge clk);
        predict(mask, data, d1, d2, stuck, tmo_v, blk);
        bus_if.wdata = data;
        bus_if.req   = mask;
        tx_block     = (blk > 0);
        n = 0;
        while (sb.size() != 0 || inflight || bus_if.req != '0) begin
            @(negedge clk);
            n++;
            if (n == blk) tx_block = 0;
            bus_if.req = bus_if.req & ~bus_if.ack;
            if (n > 3000) begin
                fail("round_timeout");
                sb.delete();
                inflight   = 0;
                bus_if.req = '0;
                tx_block   = 0;
                break;
            end
        end
        repeat (2) @(negedge clk);
        check("busy_after_round", bus_if.busy, 0);
        check("err_after_round", bus_if.err, m_err);
        if (clr != '0) begin
            bus_if.err_clr = clr;
            @(negedge clk);
            bus_if.err_clr = '0;
            m_err = m_err & ~clr;
            @(negedge clk);
            check("err_after_clear", bus_if.err, m_err);
        end
    endtask

    function automatic logic [8*N-1:0] rand_data();
        logic [8*N-1:0] d;
        for (int i = 0; i < N; i++) d[8*i +: 8] = 8'($urandom_range(0, 255));
        return d;
    endfunction

    logic [N-1:0]   r_mask;
    logic [N-1:0]   r_clr;
    logic [8*N-1:0] r_data;
    int             r_d1, r_d2, r_tmo, r_blk, r_n;
    bit             r_stuck;

    initial begin
        rst            = 1'b1;
        bus_if.req     = '0;
        bus_if.wdata   = '0;
        bus_if.err_clr = '0;
        bus_if.tmo     = '0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single requester, byte A5, 2-cycle start, 20-cycle frame.
        run_round(4'b0001, {24'h0, 8'hA5}, 2, 20, 0, 0, 0, '0);
        // Round-robin sequences.
        run_round(4'b1111, rand_data(), 1, 6, 0, 0, 0, '0);
        run_round(4'b0010, rand_data(), 2, 4, 0, 0, 0, '0);
        run_round(4'b1010, rand_data(), 2, 4, 0, 0, 0, '0);
        // Blocked transmitter at request time.
        run_round(4'b0100, rand_data(), 2, 5, 0, 0, 6, '0);
        // Watchdog with a transmitter that never leaves empty, then clear.
        run_round(4'b1000, rand_data(), 2, 5, 1, 10, 0, 4'b1000);
        // Watchdog disabled: long frame completes normally.
        run_round(4'b0001, rand_data(), 3, 40, 0, 0, 0, '0);
        // Completion and timeout in the same cycle, then one cycle later.
        run_round(4'b0010, rand_data(), 3, 7, 0, 10, 0, 4'b0010);
        run_round(4'b0010, rand_data(), 3, 7, 0, 11, 0, '0);
        // Leave an error bit set ahead of the reset test.
        run_round(4'b0100, rand_data(), 2, 10, 0, 5, 0, '0);

        // Reset in WAIT_DONE.
        g_d1 = 2; g_d2 = 60; g_stuck = 0; bus_if.tmo = '0;
        @(negedge clk);
        predict(4'b0010, rand_data(), 2, 60, 0, 0, 0);
        bus_if.wdata = rand_data();
        bus_if.wdata[15:8] = 8'(sb[0].data);
        bus_if.req = 4'b0010;
        r_n = 0;
        while (bus_if.ack == '0 && r_n < 100) begin
            @(negedge clk);
            r_n++;
        end
        if (r_n >= 100) fail("reset_test_no_ack");
        bus_if.req = '0;
        repeat (6) @(negedge clk);
        check("busy_before_reset", bus_if.busy, 1);
        rst = 1'b1;
        sb.delete();
        m_err = '0;
        m_rr  = 0;
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("done_after_reset", bus_if.done, 0);
        run_round(4'b1111, rand_data(), 2, 5, 0, 0, 0, '0);

        // Randomized rounds.
        for (int r = 0; r < 40; r++) begin
            r_mask  = N'($urandom_range(1, (1 << N) - 1));
            r_data  = rand_data();
            r_d1    = $urandom_range(1, 4);
            r_d2    = $urandom_range(1, 25);
            r_tmo   = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30);
            r_stuck = (r_tmo != 0) && ($urandom_range(0, 5) == 0);
            r_blk   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            r_clr   = N'($urandom_range(0, (1 << N) - 1));
            run_round(r_mask, r_data, r_d1, r_d2, r_stuck, r_tmo, r_blk, r_clr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
